// File: rtl/traffic_pkg.sv
// Shared types and constants for the AI traffic scheduler: lane geometry,
// the per-vehicle slot record and the scheduler FSM state encodings.
package traffic_pkg;

    localparam int NUM_LANES = 4;

    // Left edge of each lane in pixels; index 0 is the leftmost lane.
    localparam logic [NUM_LANES-1:0][10:0] LANE_X = {11'd360, 11'd300, 11'd240, 11'd180};

    // One vehicle slot: y is the top edge in two's complement so vehicles
    // can sit above the visible area while they enter or leave.
    typedef struct packed {
        logic               active;
        logic        [10:0] x;
        logic signed [11:0] y;
    } slot_t;

    // Scheduler states, kept as plain constants for older tooling.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_UPDATE = 2'd1;
    localparam logic [1:0] ST_SEARCH = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

endpackage

// File: rtl/lane_checker.sv
// Combinational lane occupancy test: a lane is free when no live vehicle
// in that lane is still close enough to the spawn line to overlap a new one.
module lane_checker
    import traffic_pkg::*;
#(
    parameter int                 NUM_SLOTS = 4,
    parameter logic signed [11:0] BLOCK_Y   = 12'sd64
) (
    input  logic [10:0] lane_x,
    input  slot_t       slots [NUM_SLOTS],
    output logic        lane_free
);

    // Scan every slot; any live vehicle in this lane above BLOCK_Y blocks it.
    always_comb begin
        // NOTE: the default assignment first keeps this purely combinational (no latch).
        lane_free = 1'b1;
        for (int j = 0; j < NUM_SLOTS; j++) begin
            if (slots[j].active && (slots[j].x == lane_x) && ($signed(slots[j].y) < BLOCK_Y))
                lane_free = 1'b0;
        end
    end

endmodule

// File: rtl/traffic_scheduler.sv
// Per-frame AI traffic scheduler. On each accepted frame_start it moves every
// live vehicle by the relative speed, retires those that left the screen,
// optionally spawns one vehicle into a free lane, then commits the whole slot
// table to the outputs in a single cycle so renderers never see a half update.
// Optional build macro TRAFFIC_DIFFICULTY_EN shortens the spawn gap as the
// player speeds up; without it the gap is always SPAWN_GAP_FRAMES.
module traffic_scheduler
    import traffic_pkg::*;
#(
    parameter int NUM_SLOTS        = 4,
    parameter int SPAWN_GAP_FRAMES = 32,
    parameter int BASE_SPEED       = 6,
    parameter int SCREEN_H         = 480,
    parameter int SPAWN_Y          = -128,
    parameter int EXIT_Y           = -256,
    parameter int CLEAR_ZONE       = 64
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        frame_start,
    input  logic [9:0]                  player_speed,
    input  logic [10:0]                 random,
    output logic [NUM_SLOTS-1:0]        slot_active,
    output logic [NUM_SLOTS-1:0][10:0]  slot_x,
    output logic [NUM_SLOTS-1:0][11:0]  slot_y,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int GAP_W = $clog2(SPAWN_GAP_FRAMES + 1);

    localparam logic [GAP_W-1:0]   GAP_INIT   = GAP_W'(SPAWN_GAP_FRAMES);
    localparam logic signed [12:0] BASE_13    = 13'(BASE_SPEED);
    localparam logic signed [12:0] SCREEN_13  = 13'(SCREEN_H);
    localparam logic signed [12:0] EXIT_13    = 13'(EXIT_Y);
    localparam logic signed [11:0] SPAWN_Y_12 = 12'(SPAWN_Y);
    localparam logic signed [11:0] BLOCK_Y_12 = 12'(SPAWN_Y + CLEAR_ZONE + 128);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [1:0]       start_lane;
    logic [1:0]       try_k;
    logic [4:0]       speed_q;      // player_speed[9:5], the only bits the math needs
    logic [GAP_W-1:0] gap;
    slot_t            work [NUM_SLOTS];

    logic signed [12:0] y_new;
    logic               new_active;
    logic               any_free;
    logic [IDX_W-1:0]   free_idx;
    logic [1:0]         lane;
    logic               lane_free;
    logic [GAP_W-1:0]   gap_reload;
    logic               unused_inputs;

    assign unused_inputs = ^{random[10:2], player_speed[4:0]};
    assign busy          = (state != ST_IDLE);
    assign lane          = start_lane + try_k;

    // Motion of the slot being updated this cycle, at 13 bits so wrap cannot hide an exit.
    always_comb begin
        y_new      = $signed({work[idx].y[11], work[idx].y}) - BASE_13
                   + $signed({8'd0, speed_q});
        new_active = work[idx].active && !((y_new >= SCREEN_13) || (y_new < EXIT_13));
    end

    // Free-slot detection; the slot updated this cycle counts with its post-update state.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int j = 0; j < NUM_SLOTS; j++) begin
            if ((IDX_W'(j) == idx) ? !new_active : !work[j].active)
                any_free = 1'b1;
        end
        for (int j = NUM_SLOTS - 1; j >= 0; j--) begin
            if (!work[j].active)
                free_idx = IDX_W'(j);
        end
    end

    // Spawn gap reload value.
`ifdef TRAFFIC_DIFFICULTY_EN
    int reload_calc;
    always_comb begin
        reload_calc = SPAWN_GAP_FRAMES - int'(speed_q[4:1]);
        if (reload_calc < 8)
            reload_calc = 8;
        gap_reload = GAP_W'(reload_calc);
    end
`else
    assign gap_reload = GAP_INIT;
`endif

    lane_checker #(
        .NUM_SLOTS (NUM_SLOTS),
        .BLOCK_Y   (BLOCK_Y_12)
    ) u_lane_checker (
        .lane_x    (LANE_X[lane]),
        .slots     (work),
        .lane_free (lane_free)
    );

    // Scheduler FSM, working table and committed output table.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state       <= ST_IDLE;
            idx         <= '0;
            start_lane  <= '0;
            try_k       <= '0;
            speed_q     <= '0;
            gap         <= GAP_INIT;
            frame_done  <= 1'b0;
            slot_active <= '0;
            slot_x      <= '0;
            slot_y      <= '0;
            // NOTE: the working table is reset explicitly; stale live slots would otherwise survive a reset.
            for (int j = 0; j < NUM_SLOTS; j++)
                work[j] <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout so every register updates from pre-edge values.
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        start_lane <= random[1:0];
                        speed_q    <= player_speed[9:5];
                        idx        <= '0;
                        state      <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    if (work[idx].active) begin
                        work[idx].y      <= y_new[11:0];
                        work[idx].active <= new_active;
                    end
                    if ((idx == '0) && (gap != '0))
                        gap <= gap - 1'b1;
                    if (idx == IDX_W'(NUM_SLOTS - 1)) begin
                        try_k <= '0;
                        state <= ((gap == '0) && any_free) ? ST_SEARCH : ST_COMMIT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_SEARCH: begin
                    if (lane_free) begin
                        work[free_idx] <= '{active: 1'b1, x: LANE_X[lane], y: SPAWN_Y_12};
                        gap            <= gap_reload;
                        state          <= ST_COMMIT;
                    end else if (try_k == 2'd3) begin
                        state <= ST_COMMIT;
                    end else begin
                        try_k <= try_k + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    for (int j = 0; j < NUM_SLOTS; j++) begin
                        slot_active[j] <= work[j].active;
                        slot_x[j]      <= work[j].x;
                        slot_y[j]      <= work[j].y;
                    end
                    frame_done <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_scheduler.sv
// Directed bench for traffic_scheduler with five slots so that all four
// lanes can be blocked while a slot is still free. Latency is counted in
// clock edges from the edge that samples frame_start to the edge that
// raises frame_done: NS+2 without a search, NS+2+n after n lane tries.
module tb_traffic_scheduler;

    localparam int NS = 5;
`ifdef TRAFFIC_DIFFICULTY_EN
    localparam int SPAWN_INTERVAL = 17;
`else
    localparam int SPAWN_INTERVAL = 32;
`endif

    logic                 clk = 1'b0;
    logic                 resetN;
    logic                 frame_start;
    logic [9:0]           player_speed;
    logic [10:0]          random;
    logic [NS-1:0]        slot_active;
    logic [NS-1:0][10:0]  slot_x;
    logic [NS-1:0][11:0]  slot_y;
    logic                 busy;
    logic                 frame_done;

    int vectors     = 0;
    int miscompares = 0;

    traffic_scheduler #(.NUM_SLOTS(NS)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .frame_start  (frame_start),
        .player_speed (player_speed),
        .random       (random),
        .slot_active  (slot_active),
        .slot_x       (slot_x),
        .slot_y       (slot_y),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // One frame: pulse frame_start, wait for frame_done, return edge count.
    task automatic run_frame(input logic [10:0] rnd, input logic [9:0] ps, output int lat);
        logic [NS-1:0]       a0;
        logic [NS-1:0][10:0] x0;
        logic [NS-1:0][11:0] y0;
        bit                  stable;
        @(negedge clk);
        random = rnd; player_speed = ps; frame_start = 1'b1;
        a0 = slot_active; x0 = slot_x; y0 = slot_y; stable = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        lat = 1;
        while (!frame_done && lat < 20) begin
            if (slot_active !== a0 || slot_x !== x0 || slot_y !== y0 || busy !== 1'b1)
                stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_done_timeout: got no frame_done within %0d cycles, expected one", lat);
        end
        vectors++;
        if (!stable) begin
            miscompares++;
            $display("FAIL table_stable_while_busy: got outputs changing or busy low mid-frame, expected stable table and busy=1");
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_after_commit: got %b, expected 0", busy);
        end
    endtask

    task automatic run_frames(input int n, input logic [10:0] rnd, input logic [9:0] ps);
        int lat;
        for (int f = 0; f < n; f++)
            run_frame(rnd, ps, lat);
    endtask

    task automatic test_reset();
        resetN = 1'b0; frame_start = 1'b0; player_speed = '0; random = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (slot_active !== '0 || slot_x !== '0 || slot_y !== '0) begin
            miscompares++;
            $display("FAIL reset_table: got active=%b x=%h y=%h, expected all 0", slot_active, slot_x, slot_y);
        end
        vectors++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got busy=%b frame_done=%b, expected 0 0", busy, frame_done);
        end
        resetN = 1'b1;
    endtask

    // Frames 1..32: no spawn until the gap expires, then lane 0 at SPAWN_Y.
    task automatic test_first_spawn();
        int lat;
        run_frame(11'd0, 10'd0, lat);
        vectors++;
        if (lat !== NS + 2) begin
            miscompares++;
            $display("FAIL idle_latency: got %0d cycles, expected %0d", lat, NS + 2);
        end
        run_frames(30, 11'd0, 10'd0);
        vectors++;
        if (slot_active !== 5'b00000) begin
            miscompares++;
            $display("FAIL no_spawn_before_gap: got active=%b, expected 00000", slot_active);
        end
        run_frame(11'd0, 10'd0, lat);
        vectors++;
        if (lat !== NS + 3) begin
            miscompares++;
            $display("FAIL spawn_latency: got %0d cycles, expected %0d", lat, NS + 3);
        end
        vectors++;
        if (slot_active !== 5'b00001 || slot_x[0] !== 11'd180 || $signed(slot_y[0]) != -128) begin
            miscompares++;
            $display("FAIL first_spawn: got active=%b x=%0d y=%0d, expected 00001 180 -128",
                     slot_active, slot_x[0], $signed(slot_y[0]));
        end
    endtask

    // Frames 33..59: move slot 0 to y=100, check +4 at speed 320, then bottom exit.
    task automatic test_motion();
        int lat;
        run_frames(9, 11'd0, 10'd992);
        run_frame(11'd0, 10'd288, lat);
        vectors++;
        if ($signed(slot_y[0]) != 100) begin
            miscompares++;
            $display("FAIL move_to_100: got y=%0d, expected 100", $signed(slot_y[0]));
        end
        run_frame(11'd0, 10'd320, lat);
        vectors++;
        if ($signed(slot_y[0]) != 104 || slot_active[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL speed_320_step: got y=%0d active=%b, expected 104 1", $signed(slot_y[0]), slot_active[0]);
        end
        run_frames(15, 11'd0, 10'd992);
        vectors++;
        if ($signed(slot_y[0]) != 479 || slot_active[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL y_479_alive: got y=%0d active=%b, expected 479 1", $signed(slot_y[0]), slot_active[0]);
        end
        run_frame(11'd0, 10'd992, lat);
        vectors++;
        if (slot_active !== 5'b00000) begin
            miscompares++;
            $display("FAIL bottom_retire: got active=%b, expected 00000", slot_active);
        end
    endtask

    // Frames 60..87: spawn in lane 2, drift up to -256 (alive) then -262 (retired).
    task automatic test_exit();
        int lat;
        run_frames(4, 11'd0, 10'd0);
        run_frame(11'd2, 10'd0, lat);
        vectors++;
        if (slot_active !== 5'b00001 || slot_x[0] !== 11'd300 || $signed(slot_y[0]) != -128) begin
            miscompares++;
            $display("FAIL spawn_lane2: got active=%b x=%0d y=%0d, expected 00001 300 -128",
                     slot_active, slot_x[0], $signed(slot_y[0]));
        end
        run_frames(17, 11'd0, 10'd0);
        run_frames(4, 11'd0, 10'd32);
        vectors++;
        if ($signed(slot_y[0]) != -250) begin
            miscompares++;
            $display("FAIL drift_to_m250: got y=%0d, expected -250", $signed(slot_y[0]));
        end
        run_frame(11'd0, 10'd0, lat);
        vectors++;
        if ($signed(slot_y[0]) != -256 || slot_active[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL exit_edge_alive: got y=%0d active=%b, expected -256 1", $signed(slot_y[0]), slot_active[0]);
        end
        run_frame(11'd0, 10'd0, lat);
        vectors++;
        if (slot_active !== 5'b00000) begin
            miscompares++;
            $display("FAIL top_retire: got active=%b, expected 00000", slot_active);
        end
    endtask

    // Frames 88..225: lane skipping, then all four lanes blocked twice in a row.
    task automatic test_lane_search();
        int lat;
        run_frames(8, 11'd0, 10'd0);
        run_frame(11'd0, 10'd0, lat);            // frame 96: lane 0 spawn
        run_frames(30, 11'd0, 10'd192);          // speed 192 holds vehicles still
        run_frame(11'd0, 10'd992, lat);          // -103
        run_frame(11'd0, 10'd288, lat);          // frame 128: -100, lane 0 blocked
        vectors++;
        if (lat !== NS + 4) begin
            miscompares++;
            $display("FAIL skip_lane0_latency: got %0d cycles, expected %0d", lat, NS + 4);
        end
        vectors++;
        if (slot_active !== 5'b00011 || slot_x[1] !== 11'd240 || $signed(slot_y[0]) != -100) begin
            miscompares++;
            $display("FAIL skip_lane0: got active=%b x1=%0d y0=%0d, expected 00011 240 -100",
                     slot_active, slot_x[1], $signed(slot_y[0]));
        end
        run_frames(31, 11'd0, 10'd192);
        run_frame(11'd2, 10'd192, lat);          // frame 160
        run_frames(31, 11'd0, 10'd192);
        run_frame(11'd3, 10'd192, lat);          // frame 192
        vectors++;
        if (slot_active !== 5'b01111 || slot_x[2] !== 11'd300 || slot_x[3] !== 11'd360) begin
            miscompares++;
            $display("FAIL fill_lanes: got active=%b x2=%0d x3=%0d, expected 01111 300 360",
                     slot_active, slot_x[2], slot_x[3]);
        end
        run_frames(31, 11'd0, 10'd192);
        for (int f = 0; f < 2; f++) begin        // frames 224 and 225
            run_frame(11'd1, 10'd192, lat);
            vectors++;
            if (lat !== NS + 6 || slot_active !== 5'b01111) begin
                miscompares++;
                $display("FAIL all_lanes_blocked: got lat=%0d active=%b, expected %0d 01111", lat, slot_active, NS + 6);
            end
        end
    endtask

    // Frames 226..263: clear lane 0 only, spawn via wrap-around, fill all slots.
    task automatic test_wrap_and_fill();
        int lat;
        run_frames(6, 11'd1, 10'd992);
        run_frame(11'd1, 10'd992, lat);          // frame 232: only lane 0 free
        vectors++;
        if (lat !== NS + 6 || slot_active !== 5'b11111 || slot_x[4] !== 11'd180) begin
            miscompares++;
            $display("FAIL wrap_to_lane0: got lat=%0d active=%b x4=%0d, expected %0d 11111 180",
                     lat, slot_active, slot_x[4], NS + 6);
        end
        run_frames(31, 11'd0, 10'd192);
    endtask

    // Frame 264: no free slot, gap 0 -> no search; extra frame_start while busy ignored.
    task automatic test_busy_ignore();
        int lat   = 0;
        int dones = 0;
        @(negedge clk);
        random = 11'd0; player_speed = 10'd192; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            if (frame_done === 1'b1) begin
                dones++;
                if (lat == 0) lat = c;
            end
            frame_start = (c == 2);
            @(negedge clk);
        end
        frame_start = 1'b0;
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL busy_ignore_done_count: got %0d frame_done pulses, expected 1", dones);
        end
        vectors++;
        if (lat !== NS + 2) begin
            miscompares++;
            $display("FAIL full_table_latency: got %0d cycles, expected %0d", lat, NS + 2);
        end
        run_frame(11'd0, 10'd192, lat);
        vectors++;
        if (lat !== NS + 2 || slot_active !== 5'b11111) begin
            miscompares++;
            $display("FAIL full_table_retry: got lat=%0d active=%b, expected %0d 11111", lat, slot_active, NS + 2);
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        random = 11'd0; player_speed = 10'd192; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_in_update: got %b, expected 1", busy);
        end
        resetN = 1'b0;
        @(negedge clk);
        vectors++;
        if (slot_active !== '0 || slot_x !== '0 || slot_y !== '0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_frame_reset: got active=%b busy=%b done=%b, expected all 0", slot_active, busy, frame_done);
        end
        resetN = 1'b1;
    endtask

    // From a fresh reset at full speed: first spawn on frame 32, next SPAWN_INTERVAL later.
    task automatic test_difficulty();
        int  lat;
        int  first  = 0;
        int  second = 0;
        bit  spawned;
        for (int f = 1; f <= 70; f++) begin
            run_frame(11'd0, 10'd1023, lat);
            spawned = 1'b0;
            for (int s = 0; s < NS; s++)
                if (slot_active[s] && $signed(slot_y[s]) == -128) spawned = 1'b1;
            if (spawned && first == 0) first = f;
            else if (spawned && second == 0) second = f;
        end
        vectors++;
        if (first !== 32) begin
            miscompares++;
            $display("FAIL gap_after_reset: got first spawn at frame %0d, expected 32", first);
        end
        vectors++;
        if (second - first !== SPAWN_INTERVAL) begin
            miscompares++;
            $display("FAIL spawn_interval: got %0d frames, expected %0d", second - first, SPAWN_INTERVAL);
        end
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_motion();
        test_exit();
        test_lane_search();
        test_wrap_and_fill();
        test_busy_ignore();
        test_reset_mid_frame();
        test_difficulty();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
